// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// uart_rx_cfg: oversampling UART receiver with 3-sample vote, parity/stop checks and a valid/ready output.
// Break detection is built in when UART_RX_BREAK_DET_EN is defined.
//   state  | meaning
//   IDLE   | line idle, waiting for a 1->0 edge
//   START  | confirming the start bit at mid-bit
//   DATA   | shifting in data bits, LSB first
//   PARITY | sampling the parity bit
//   STOP   | sampling stop bit(s); commit after the last one
//   BREAK  | line held low through a whole frame; wait for one bit of high
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  SMP_A     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  SMP_B     = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  SMP_C     = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_RX_BREAK_DET_EN
    , S_BREAK = 3'd5
`endif
  } state_t;

  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  state_t               state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_err_q, stop_err_d;
  logic                 commit_q, commit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_overrun_q, rx_overrun_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                 any_one_q, any_one_d;
  logic                 rx_break_q, rx_break_d;
`endif

  logic rx_s, fall, tick, vote, vote_pt, par_calc, par_err;

  always_comb begin
    rx_s     = sync2_q;
    fall     = prev_q & ~sync2_q;
    tick     = (div_cnt_q == DIV_LAST);
    vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    vote_pt  = tick && (os_cnt_q == SMP_C);
    par_calc = ^{shift_q, par_q};
    par_err  = (PARITY == 1) ? ~par_calc : (PARITY == 2) ? par_calc : 1'b0;

    sync1_d      = rx_serial;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    smp_d        = smp_q;
    shift_d      = shift_q;
    par_d        = par_q;
    stop_err_d   = stop_err_q;
    commit_d     = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_perr_d    = rx_perr_q;
    rx_ferr_d    = rx_ferr_q;
    rx_overrun_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    any_one_d    = any_one_q;
    rx_break_d   = rx_break_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d    = S_START;
          os_cnt_d   = '0;
          bit_cnt_d  = '0;
          stop_err_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          any_one_d  = 1'b0;
`endif
        end
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        if (tick) begin
          os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
          if (os_cnt_q == SMP_A) smp_d[0] = rx_s;
          if (os_cnt_q == SMP_B) smp_d[1] = rx_s;
        end
        // State changes happen at the vote point; os_cnt keeps the bit phase.
        if (vote_pt) begin
`ifdef UART_RX_BREAK_DET_EN
          if (state_q != S_START) any_one_d = any_one_q | vote;
`endif
          case (state_q)
            S_START: state_d = vote ? S_IDLE : S_DATA;
            S_DATA: begin
              shift_d = {vote, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == DATA_LAST) begin
                bit_cnt_d = '0;
                state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end
            S_PARITY: begin
              par_d   = vote;
              state_d = S_STOP;
            end
            S_STOP: begin
              stop_err_d = stop_err_q | ~vote;
              if (bit_cnt_q == STOP_LAST) begin
                commit_d = 1'b1;
                state_d  = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                if (!(any_one_q | vote)) begin
                  state_d  = S_BREAK;
                  os_cnt_d = '0;
                end
`endif
              end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      S_BREAK: begin
        // Count ticks of continuous high; any low sample restarts the bit.
        if (!rx_s) begin
          os_cnt_d = '0;
        end else if (tick) begin
          if (os_cnt_q == OS_LAST) begin
            state_d  = S_IDLE;
            os_cnt_d = '0;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (commit_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_perr_d  = par_err;
        rx_ferr_d  = stop_err_q;
        rx_valid_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
        rx_break_d = ~any_one_q;
`endif
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      rx_break_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      div_cnt_q    <= '0;
      state_q      <= S_IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      smp_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_err_q   <= 1'b0;
      commit_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      any_one_q    <= 1'b0;
      rx_break_q   <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop_err_q   <= stop_err_d;
      commit_q     <= commit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_perr_q    <= rx_perr_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_overrun_q <= rx_overrun_d;
`ifdef UART_RX_BREAK_DET_EN
      any_one_q    <= any_one_d;
      rx_break_q   <= rx_break_d;
`endif
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_overrun_q;
`ifdef UART_RX_BREAK_DET_EN
  assign rx_break      = rx_break_q;
`else
  assign rx_break      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Bench for uart_rx_cfg: 8N1 instance and a 7-bit even-parity instance driven by directed and random frames.
module tb_uart_rx_cfg;

  localparam int BIT = 432;
  localparam int GAP = BIT / 2;
`ifdef UART_RX_BREAK_DET_EN
  localparam logic BRK_EN = 1'b1;
`else
  localparam logic BRK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_;
  logic       line_a, line_b, rdy_a, rdy_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, perr_a, ferr_a, ovr_a, brk_a;
  logic       valid_b, perr_b, ferr_b, ovr_b, brk_b;

  uart_rx_cfg dut_a (
    .clk(clk), .rst_(rst_), .rx_serial(line_a), .rx_ready(rdy_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_parity_err(perr_a),
    .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .rx_break(brk_a));

  uart_rx_cfg #(.PARITY(2), .DATA_BITS(7)) dut_b (
    .clk(clk), .rst_(rst_), .rx_serial(line_b), .rx_ready(rdy_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_parity_err(perr_b),
    .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .rx_break(brk_b));

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt_a = 0;
  int ovr_base;
  logic [11:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  logic [8:0]  rd;
  logic        sv, pf;

  // Words are {break, frame_err, parity_err, data[8:0]}, captured on accepted handshakes.
  always @(negedge clk) begin
    if (rst_ && valid_a && rdy_a) got_a.push_back({brk_a, ferr_a, perr_a, 1'b0, data_a});
    if (rst_ && valid_b && rdy_b) got_b.push_back({brk_b, ferr_b, perr_b, 2'b00, data_b});
    if (ovr_a) ovr_cnt_a++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [8:0] d, input int nbits,
                                        input logic pbad, input logic stop_v);
    logic [8:0] m;
    m = 9'h1FF >> (9 - nbits);
    return {1'b0, ~stop_v, pbad, d & m};
  endfunction

  task automatic send_bits(input bit which, input logic v, input int ncyc);
    if (which) line_b = v; else line_a = v;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit which, input logic [8:0] d, input int nbits, input int pmode,
                            input logic pflip, input logic stop_v, input int bclk);
    logic x, p;
    x = 1'b0;
    send_bits(which, 1'b0, bclk);
    for (int i = 0; i < nbits; i++) begin
      x = x ^ d[i];
      send_bits(which, d[i], bclk);
    end
    if (pmode != 0) begin
      p = (pmode == 1) ? ~x : x;
      send_bits(which, p ^ pflip, bclk);
    end
    send_bits(which, stop_v, bclk);
    if (which) line_b = 1'b1; else line_a = 1'b1;
  endtask

  task automatic compare_q(input bit which, input string tag);
    int ng, ne;
    ng = which ? got_b.size() : got_a.size();
    ne = which ? exp_b.size() : exp_a.size();
    check({tag, "_count"}, 32'(ng), 32'(ne));
    for (int i = 0; i < ng && i < ne; i++)
      check({tag, "_word"}, 32'(which ? got_b[i] : got_a[i]), 32'(which ? exp_b[i] : exp_a[i]));
    if (which) begin got_b.delete(); exp_b.delete(); end
    else begin got_a.delete(); exp_a.delete(); end
  endtask

  initial begin
    rst_ = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; line_a = 1'b1; line_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_a", {valid_a, perr_a, ferr_a, ovr_a, brk_a, data_a}, 32'h0);
    check("reset_b", {valid_b, perr_b, ferr_b, ovr_b, brk_b, data_b}, 32'h0);
    @(posedge clk); #1 rst_ = 1'b1;
    send_bits(0, 1'b1, BIT);

    exp_a.push_back(model(9'h0A5, 8, 1'b0, 1'b1));
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, BIT);
    send_bits(0, 1'b1, GAP);
    compare_q(0, "a5_8n1");

    exp_b.push_back(model(9'h035, 7, 1'b1, 1'b1));
    send_frame(1, 9'h035, 7, 2, 1'b1, 1'b1, BIT);
    send_bits(1, 1'b1, GAP);
    compare_q(1, "par_bad");
    exp_b.push_back(model(9'h035, 7, 1'b0, 1'b1));
    send_frame(1, 9'h035, 7, 2, 1'b0, 1'b1, BIT);
    send_bits(1, 1'b1, GAP);
    compare_q(1, "par_ok");

    exp_a.push_back(model(9'h03C, 8, 1'b0, 1'b0));
    exp_a.push_back(model(9'h011, 8, 1'b0, 1'b1));
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b0, BIT);
    send_bits(0, 1'b1, GAP);
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, BIT);
    send_bits(0, 1'b1, GAP);
    compare_q(0, "stop_low");

    ovr_base = ovr_cnt_a;
    rdy_a = 1'b0;
    send_frame(0, 9'h001, 8, 0, 1'b0, 1'b1, BIT);
    send_bits(0, 1'b1, GAP);
    check("held_valid", 32'(valid_a), 32'h1);
    send_frame(0, 9'h002, 8, 0, 1'b0, 1'b1, BIT);
    send_bits(0, 1'b1, GAP);
    check("ovr_keep_data", 32'(data_a), 32'h01);
    check("ovr_pulses", 32'(ovr_cnt_a - ovr_base), 32'h1);
    rdy_a = 1'b1;
    @(posedge clk); #1 rdy_a = 1'b0;
    @(negedge clk);
    check("after_hs_valid", 32'(valid_a), 32'h0);
    rdy_a = 1'b1;
    exp_a.push_back(model(9'h001, 8, 1'b0, 1'b1));
    compare_q(0, "ovr_word");

    send_bits(0, 1'b0, BIT / 4);
    send_bits(0, 1'b1, BIT);
    compare_q(0, "glitch");
    exp_a.push_back(model(9'h07E, 8, 1'b0, 1'b1));
    send_frame(0, 9'h07E, 8, 0, 1'b0, 1'b1, 419);
    send_bits(0, 1'b1, GAP);
    compare_q(0, "fast_baud");

    for (int i = 0; i < 2; i++) begin
      rd = 9'($urandom_range(0, 255));
      sv = ($urandom_range(0, 3) != 0);
      if (rd == 9'h0) sv = 1'b1;
      exp_a.push_back(model(rd, 8, 1'b0, sv));
      send_frame(0, rd, 8, 0, 1'b0, sv, BIT);
      send_bits(0, 1'b1, GAP);
      compare_q(0, "rand_a");
    end
    rd = 9'($urandom_range(0, 127));
    pf = 1'($urandom_range(0, 1));
    exp_b.push_back(model(rd, 7, pf, 1'b1));
    send_frame(1, rd, 7, 2, pf, 1'b1, BIT);
    send_bits(1, 1'b1, GAP);
    compare_q(1, "rand_b");

    rdy_a = 1'b0;
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, BIT);
    send_bits(0, 1'b1, GAP);
    check("pre_rst_data", {23'h0, valid_a, data_a}, 32'h15A);
    send_bits(0, 1'b0, BIT);
    send_bits(0, 1'b1, BIT);
    send_bits(0, 1'b0, BIT / 2);
    #5 rst_ = 1'b0;
    #2 check("async_rst", {valid_a, perr_a, ferr_a, ovr_a, brk_a, data_a}, 32'h0);
    line_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1; rdy_a = 1'b1;
    send_bits(0, 1'b1, BIT);
    compare_q(0, "after_rst");

    exp_a.push_back({BRK_EN, 1'b1, 1'b0, 9'h000});
    send_bits(0, 1'b0, BIT * 20);
    send_bits(0, 1'b1, BIT * 2);
    compare_q(0, "break");
    exp_a.push_back(model(9'h055, 8, 1'b0, 1'b1));
    send_frame(0, 9'h055, 8, 0, 1'b0, 1'b1, BIT);
    send_bits(0, 1'b1, GAP);
    compare_q(0, "post_break");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
